// File: rtl/tree_second_if.sv
// Handshake bundle between the up-sweep tree, this down-sweep tree and the
// per-group sum logic. The master side feeds beats in and drains them out.
interface tree_second_if #(
  parameter int GROUPS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*GROUPS-1:0]   in_gp;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*GROUPS-1:0]   out_gp;
  logic [GROUPS-1:0]     out_carry;

  modport master (
    output in_valid, in_gp, in_cin, out_ready,
    input  in_ready, out_valid, out_gp, out_carry
  );

  modport slave (
    input  in_valid, in_gp, in_cin, out_ready,
    output in_ready, out_valid, out_gp, out_carry
  );
endinterface

// File: rtl/tree_second.sv
// Down-sweep half of the group-level Brent-Kung carry-prefix network.
// Takes the sparse up-sweep spans, fills in the missing prefixes one tree
// level per clock, and forms the group carries from the carry-in that
// travels alongside each beat.

// Prefix combine: (G,P) of the high span absorbs the adjacent low span.
module o_logic (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

module tree_second #(
  parameter  int GROUPS = 8,
  localparam int LEVELS = $clog2(GROUPS) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  tree_second_if.slave  bus
);
  localparam int W = 2 * GROUPS;

  logic [LEVELS-1:0]         vld;
  logic [LEVELS-1:0]         rdy;
  logic [LEVELS-1:0]         up_vld;
  logic [LEVELS-1:0]         up_cin;
  logic [LEVELS-1:0]         cin_q;
  logic [LEVELS-1:0][W-1:0]  gp_q;
  logic [LEVELS-1:0][W-1:0]  src;
  logic [LEVELS-1:0][W-1:0]  nxt;

  // Upstream view of each stage: the input port for stage 0, the previous
  // stage register otherwise.
  always_comb begin
    up_vld    = '0;
    up_cin    = '0;
    src       = '0;
    up_vld[0] = bus.in_valid;
    up_cin[0] = bus.in_cin;
    src[0]    = bus.in_gp;
    for (int s = 1; s < LEVELS; s++) begin
      up_vld[s] = vld[s-1];
      up_cin[s] = cin_q[s-1];
      src[s]    = gp_q[s-1];
    end
  end

  // Ready ripples backwards: a stage can load if it is empty or the stage
  // after it is loading this cycle.
  always_comb begin
    rdy           = '0;
    rdy[LEVELS-1] = bus.out_ready | ~vld[LEVELS-1];
    for (int s = LEVELS - 2; s >= 0; s--) begin
      rdy[s] = rdy[s+1] | ~vld[s];
    end
  end

  // Stage s works at distance 2^d with d = LEVELS-1-s; pairs sitting halfway
  // between two already-complete prefixes pick up the lower one.
  for (genvar s = 0; s < LEVELS; s++) begin : g_stage
    localparam int D = LEVELS - 1 - s;
    for (genvar k = 0; k < GROUPS; k++) begin : g_pair
      if ((((k + 1) % (2 ** (D + 1))) == (2 ** D)) && (k >= 2 ** (D + 1))) begin : g_comb
        o_logic u_o (
          .gh (src[s][2*k+1]),
          .ph (src[s][2*k]),
          .gl (src[s][2*(k-2**D)+1]),
          .pl (src[s][2*(k-2**D)]),
          .g  (nxt[s][2*k+1]),
          .p  (nxt[s][2*k])
        );
      end else begin : g_pass
        assign nxt[s][2*k+1 -: 2] = src[s][2*k+1 -: 2];
      end
    end
  end

  // Pipeline registers; data only captures real beats so bubbles never
  // carry stale or unknown values forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= '0;
      cin_q <= '0;
      gp_q  <= '0;
    end else begin
      for (int s = 0; s < LEVELS; s++) begin
        if (rdy[s]) begin
          vld[s] <= up_vld[s];
          if (up_vld[s]) begin
            gp_q[s]  <= nxt[s];
            cin_q[s] <= up_cin[s];
          end
        end
      end
    end
  end

  // Group carries straight from the last register and its stored carry-in.
  always_comb begin
    bus.out_carry = '0;
    for (int k = 0; k < GROUPS; k++) begin
      bus.out_carry[k] = gp_q[LEVELS-1][2*k+1] | (gp_q[LEVELS-1][2*k] & cin_q[LEVELS-1]);
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[LEVELS-1];
  assign bus.out_gp    = gp_q[LEVELS-1];
endmodule

// File: tb/tb_tree_second.sv
// Bench for tree_second with 8 groups: directed vectors, back-to-back
// random beats, backpressure, random flow control and mid-stream reset.
module tb_tree_second;
  localparam int GROUPS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tree_second_if #(.GROUPS(GROUPS)) bus ();

  tree_second #(.GROUPS(GROUPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] gp;
    logic        cin;
    logic [15:0] egp;
    logic [7:0]  ec;
  } vec_t;

  vec_t        vecs [7];
  int          total = 0;
  int          bad = 0;
  int          stalls = 0;
  logic        mon_en = 1'b0;
  logic        rand_mode = 1'b0;
  logic        fix_rdy = 1'b1;
  logic        rnd_bit = 1'b1;
  logic [15:0] cur_egp = '0;
  logic [7:0]  cur_ec = '0;
  logic [23:0] sb [$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_gp;
  logic [7:0]  hold_c;

  assign bus.out_ready = rand_mode ? rnd_bit : fix_rdy;

  always @(posedge clk) rnd_bit <= ($urandom_range(0, 9) < 6);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] span(input logic [7:0] g, input logic [7:0] p,
                                      input int lo, input int hi);
    logic gg, pp;
    gg = g[lo];
    pp = p[lo];
    for (int i = lo + 1; i <= hi; i++) begin
      gg = g[i] | (p[i] & gg);
      pp = pp & p[i];
    end
    return {gg, pp};
  endfunction

  // Builds the up-sweep form of a random (G,P) vector, and the serial
  // prefix scan / ripple carries it must turn into.
  task automatic gen(input logic cin, output logic [15:0] gp,
                     output logic [15:0] egp, output logic [7:0] ec);
    logic [7:0]  g, p, c;
    logic [15:0] a, e;
    logic [1:0]  s;
    int          sz;
    g = 8'($urandom);
    p = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      sz = (k + 1) & -(k + 1);
      s = span(g, p, k + 1 - sz, k);
      a[2*k +: 2] = s;
      s = span(g, p, 0, k);
      e[2*k +: 2] = s;
      c[k] = s[1] | (s[0] & cin);
    end
    gp = a; egp = e; ec = c;
  endtask

  // Offer one beat, hold it until accepted; returns at 1ns past the
  // accepting edge.
  task automatic send(input logic [15:0] gp, input logic cin,
                      input logic [15:0] egp, input logic [7:0] ec);
    int   n;
    logic acc;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_gp    = gp;
    bus.in_cin   = cin;
    cur_egp      = egp;
    cur_ec       = ec;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    bus.in_valid = 1'b0;
    stalls += n - 1;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: record accepted beats, check delivered beats in order and
  // that a stalled output does not move.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.in_valid && bus.in_ready) sb.push_back({cur_egp, cur_ec});
      if (hold_pend) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_gp", 32'(bus.out_gp), 32'(hold_gp));
        check("hold_carry", 32'(bus.out_carry), 32'(hold_c));
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_gp   = bus.out_gp;
      hold_c    = bus.out_carry;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(bus.out_gp), 32'hFFFFFFFF);
        end else begin
          logic [23:0] e;
          e = sb.pop_front();
          check("sb_gp", 32'(bus.out_gp), 32'(e[23:8]));
          check("sb_carry", 32'(bus.out_carry), 32'(e[7:0]));
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    logic [15:0] gp, egp;
    logic [7:0]  ec;
    logic        cin;
    int          gap;

    vecs[0] = '{16'h5555, 1'b1, 16'h5555, 8'hFF};
    vecs[1] = '{16'h5555, 1'b0, 16'h5555, 8'h00};
    vecs[2] = '{16'h959A, 1'b0, 16'hAAAA, 8'hFF};
    vecs[3] = '{16'h0000, 1'b1, 16'h0000, 8'h00};
    vecs[4] = '{16'hFFFF, 1'b0, 16'hFFFF, 8'hFF};
    vecs[5] = '{16'h9A55, 1'b0, 16'hAA55, 8'hF0};
    vecs[6] = '{16'h9A55, 1'b1, 16'hAA55, 8'hFF};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_gp    = '0;
    bus.in_cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_gp", 32'(bus.out_gp), 32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency checked on each.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].gp, vecs[i].cin, vecs[i].egp, vecs[i].ec);
      check($sformatf("vec%0d_lat0", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lat1", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_gp", i), 32'(bus.out_gp), 32'(vecs[i].egp));
      check($sformatf("vec%0d_carry", i), 32'(bus.out_carry), 32'(vecs[i].ec));
      @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back random beats must never stall with out_ready held high.
    stalls = 0;
    for (int i = 0; i < 10000; i++) begin
      cin = 1'($urandom);
      gen(cin, gp, egp, ec);
      send(gp, cin, egp, ec);
    end
    check("throughput_stalls", 32'(stalls), 32'd0);
    drain();

    // Backpressure: two beats fill the pipe, the third must wait.
    fix_rdy = 1'b0;
    send(vecs[0].gp, vecs[0].cin, vecs[0].egp, vecs[0].ec);
    send(vecs[2].gp, vecs[2].cin, vecs[2].egp, vecs[2].ec);
    bus.in_valid = 1'b1;
    bus.in_gp    = vecs[5].gp;
    bus.in_cin   = vecs[5].cin;
    cur_egp      = vecs[5].egp;
    cur_ec       = vecs[5].ec;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_head_gp", 32'(bus.out_gp), 32'(vecs[0].egp));
      @(posedge clk);
      #1;
    end
    fix_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();

    // Random valid gaps with random downstream readiness.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cin = 1'($urandom);
      gen(cin, gp, egp, ec);
      send(gp, cin, egp, ec);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    drain();

    // Reset with two beats in flight; they must never reappear.
    fix_rdy = 1'b0;
    send(vecs[4].gp, vecs[4].cin, vecs[4].egp, vecs[4].ec);
    send(vecs[6].gp, vecs[6].cin, vecs[6].egp, vecs[6].ec);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_gp", 32'(bus.out_gp), 32'd0);
    check("mid_rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    fix_rdy = 1'b1;
    @(posedge clk);
    #1;
    send(vecs[3].gp, vecs[3].cin, vecs[3].egp, vecs[3].ec);
    drain();
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tree_second.md
Name: tree_second

Overview:
- Pipelined down-sweep (back half) of the group-level Brent-Kung carry-prefix network.
- Input is the sparse up-sweep result produced by the first prefix tree. Pair k holds the span [k : k+1-2^t], where 2^t is the largest power of two dividing k+1.
- The block fills in every missing prefix so that each pair k holds [k:0]. It then forms the group carries from a carry-in.
- One tree level is computed per clock, with a valid/ready handshake on both sides. It sits between tree_first and the per-group sum logic of the adder.

Parameters:
- GROUPS, default `INPUTSIZE / `GROUPSIZE (8 for a 32-bit adder). Number of groups; must be a power of two, >= 4.
- LEVELS, default log2(GROUPS)-1 (2 for GROUPS=8). Number of down-sweep levels, which equals pipeline depth. Derived; not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  in_gp/in_cin valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_gp  input  2*GROUPS  up-sweep prefixes. Pair k = bits [2k+1:2k], with bit 2k+1 = G and bit 2k = P.
- in_cin  input  1  adder carry-in, travels with its beat.
- out_valid  output  1  out_gp/out_carry valid.
- out_ready  input  1  downstream accepts.
- out_gp  output  2*GROUPS  full prefixes; pair k = (G,P) over [k:0].
- out_carry  output  GROUPS  bit k = carry out of group k = G[k:0] | (P[k:0] & cin).

Behaviour:
- Combine operator o(h,l): G = Gh | (Ph & Gl); P = Ph & Pl. This is identical to o_logic, which is instantiated per combine.
- Stage s (s = 0..LEVELS-1) uses d = LEVELS-1-s.
  - Pairs k with (k+1) mod 2^(d+1) == 2^d and k >= 2^(d+1) become o(pair k, pair k-2^d).
  - All other pairs pass through unchanged.
  - The stage result is registered together with cin and a valid bit vld[s].
- GROUPS=8 example:
  - Stage 0 updates pair 5 (5:4 o 3:0).
  - Stage 1 updates pairs 2, 4 and 6.
- Pairs 0, 1, 3, 7 (all 2^n-1) are never modified.
- out_gp = stage LEVELS-1 data register. out_carry is combinational from that register and its stored cin.
- out_valid = vld[LEVELS-1].
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+LEVELS-1. This is LEVELS register stages, counted from the acceptance edge.
- Throughput: one beat per cycle when out_ready stays 1.
- Flow control:
  - ready[LEVELS-1] = out_ready | ~vld[LEVELS-1].
  - ready[s] = ready[s+1] | ~vld[s].
  - in_ready = ready[0].
  - Stage s loads when ready[s]=1, taking vld from the upstream valid (in_valid for s=0).
  - A stage does not load when ready[s]=0; it holds data and valid.
- A beat transfers only on valid & ready. out_gp/out_carry remain stable while out_valid=1 and out_ready=0.
- Simultaneous in/out transfer on a full pipeline is allowed: everything shifts by one stage with no bubble.
- in_ready may depend combinationally on out_ready. No combinational path exists from in_* data to out_*.
- Reset: while rst_n=0 at an edge, all vld bits, data registers and stored cin are cleared. Consequences:
  - out_valid=0, out_gp=0, out_carry=0.
  - in_ready=1 from the first cycle after reset.
  - In-flight beats are discarded. Reset asserted mid-stream drops everything; no partial output.
- No X propagation: data registers load only when the stage loads. Data registers of an empty stage are don't-care but reset to 0.

Test Plan:
- GROUPS=8, in_gp=16'h5555 (all P=1, G=0), in_cin=1, out_ready=1 -> after 2 edges out_valid=1, out_gp=16'h5555, out_carry=8'hFF. Same beat with in_cin=0 -> out_carry=8'h00.
- in_gp=16'h959A (group 0 G=1 P=0, others P=1, up-sweep form), cin=0 -> out_gp=16'hAAAA, out_carry=8'hFF.
- Random 8-group (G,P) vectors, with in_gp built by a reference up-sweep model -> out_gp equals the serial prefix scan and out_carry equals the serial ripple, for 10k beats back-to-back with 1/cycle throughput.
- Backpressure: out_ready=0, offer 3 beats.
  - Required: 2 beats accepted, in_ready=0 on the third, outputs held stable.
  - Release out_ready: beats emerge in order, the third is accepted the same cycle, no loss or duplication.
- Random in_valid/out_ready toggling, scoreboard check -> order preserved, no drops.
- Reset mid-stream with 2 beats in flight, rst_n=0 for 1 edge -> next cycle out_valid=0, out_gp=0, out_carry=0, in_ready=1. The dropped beats never appear.
